fixed_act_cast_pipe: RTL and testbench

- Pipelined fixed-point requantiser directly upstream of the ELU activation stage.
- Converts wide accumulator outputs, signed Q(IN_W-IN_F).IN_F, into the narrow signed format the activation LUT indexes.
- Uses round-half-up and saturation.
- Full-throughput valid/ready pipeline with backpressure, plus a saturation event counter for debug.

---
 rtl/fixed_act_cast_pipe_pkg.sv | 26 ++
 rtl/fixed_round_sat.sv | 54 +++++
 rtl/fixed_act_cast_pipe.sv | 95 +++++++++
 tb/tb_fixed_act_cast_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_act_cast_pipe_pkg.sv
// Shared constants and width helpers for the accumulator-to-activation requantiser.
// The localparams describe the default Q8.8 -> Q4.4, single-lane configuration.
package fixed_act_cast_pipe_pkg;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int shift_calc(input int in_f, input int out_f);
        return in_f - out_f;
    endfunction

    // Wide enough that neither the +half bias nor a left shift can overflow
    function automatic int rw_calc(input int in_w, input int s);
        return max_int(in_w + 1, in_w - s + 1);
    endfunction

    localparam int N       = 1;
    localparam int S       = shift_calc(8, 4);
    localparam int RW      = rw_calc(16, S);
    localparam int OUT_MAX = (1 << 7) - 1;
    localparam int OUT_MIN = -(1 << 7);

    typedef logic signed [RW-1:0] rnd_t;

endpackage

// File: rtl/fixed_round_sat.sv
// Per-lane requantiser datapath, purely combinational.
// Rounding (x -> x_rnd) feeds stage A; clamping (r -> y, clamp) reads stage A.
module fixed_round_sat
    import fixed_act_cast_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int IN_F  = 8,
    parameter int OUT_W = 8,
    parameter int OUT_F = 4,
    parameter int SHIFT = shift_calc(IN_F, OUT_F),
    parameter int R_W   = rw_calc(IN_W, SHIFT)
) (
    input  logic [IN_W-1:0]  x,
    output logic [R_W-1:0]   x_rnd,
    input  logic [R_W-1:0]   r,
    output logic [OUT_W-1:0] y,
    output logic             clamp
);
    localparam int C_W = max_int(R_W, OUT_W) + 1;
    localparam logic signed [C_W-1:0] MAXV = signed'((C_W'(1) << (OUT_W - 1)) - C_W'(1));
    localparam logic signed [C_W-1:0] MINV = ~MAXV;

    logic signed [R_W-1:0] xe;
    logic signed [C_W-1:0] re;

    assign xe = R_W'(signed'(x));

    // Adding half an output LSB then flooring gives round-half-up, so -0.5 LSB -> 0
    if (SHIFT > 0) begin : g_down
        localparam logic signed [R_W-1:0] HALF = signed'(R_W'(1) << (SHIFT - 1));
        logic signed [R_W-1:0] biased;
        assign biased = xe + HALF;
        assign x_rnd  = biased >>> SHIFT;
    end else if (SHIFT == 0) begin : g_same
        assign x_rnd = xe;
    end else begin : g_up
        assign x_rnd = xe <<< (-SHIFT);
    end

    assign re = C_W'(signed'(r));

    always_comb begin
        clamp = 1'b0;
        y     = re[OUT_W-1:0];
        if (re > MAXV) begin
            clamp = 1'b1;
            y     = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (re < MINV) begin
            clamp = 1'b1;
            y     = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fixed_act_cast_pipe.sv
// Requantises signed accumulator lanes to the activation LUT format (round-half-up, saturate).
// Latency 2 cycles (A: rounded, B: clamped), 1 beat/cycle throughput.
// Backpressure: each stage holds when the stage after it is full and stalled; no bubbles.
module fixed_act_cast_pipe
    import fixed_act_cast_pipe_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int SAT_CNT_WIDTH               = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic [SAT_CNT_WIDTH-1:0]          sat_count
);
    localparam int LANES = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int SHIFT = shift_calc(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);
    localparam int R_W   = rw_calc(DATA_IN_0_PRECISION_0, SHIFT);

    logic                              a_vld;
    logic                              b_vld;
    logic                              adv_a;
    logic                              adv_b;
    logic [R_W-1:0]                    rnd_d [LANES];
    logic [R_W-1:0]                    rnd_q [LANES];
    logic [DATA_OUT_0_PRECISION_0-1:0] sat_d [LANES];
    logic [LANES-1:0]                  clamp;
    logic [SAT_CNT_WIDTH:0]            n_clamp;
    logic [SAT_CNT_WIDTH:0]            cnt_sum;
    logic [SAT_CNT_WIDTH-1:0]          cnt_next;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fixed_round_sat #(
            .IN_W  (DATA_IN_0_PRECISION_0),
            .IN_F  (DATA_IN_0_PRECISION_1),
            .OUT_W (DATA_OUT_0_PRECISION_0),
            .OUT_F (DATA_OUT_0_PRECISION_1),
            .SHIFT (SHIFT),
            .R_W   (R_W)
        ) u_round_sat (
            .x     (data_in_0[g]),
            .x_rnd (rnd_d[g]),
            .r     (rnd_q[g]),
            .y     (sat_d[g]),
            .clamp (clamp[g])
        );
    end

    assign adv_b            = !b_vld || data_out_0_ready;
    assign adv_a            = !a_vld || adv_b;
    assign data_in_0_ready  = adv_a && rst;
    assign data_out_0_valid = b_vld;

    // Extra top bit of the sum flags overflow so the counter sticks at all-ones
    always_comb begin
        n_clamp = '0;
        for (int i = 0; i < LANES; i++) begin
            n_clamp = n_clamp + (SAT_CNT_WIDTH+1)'(clamp[i]);
        end
        cnt_sum  = {1'b0, sat_count} + n_clamp;
        cnt_next = cnt_sum[SAT_CNT_WIDTH] ? '1 : cnt_sum[SAT_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_vld     <= 1'b0;
            b_vld     <= 1'b0;
            sat_count <= '0;
            for (int i = 0; i < LANES; i++) begin
                rnd_q[i]      <= '0;
                data_out_0[i] <= '0;
            end
        end else begin
            if (adv_a) begin
                a_vld <= data_in_0_valid;
                for (int i = 0; i < LANES; i++) rnd_q[i] <= rnd_d[i];
            end
            if (adv_b) begin
                b_vld <= a_vld;
                for (int i = 0; i < LANES; i++) data_out_0[i] <= sat_d[i];
                if (a_vld) sat_count <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_fixed_act_cast_pipe.sv
// Directed bench for fixed_act_cast_pipe: default Q8.8 -> Q4.4 instance plus a
// 4-bit sat-counter instance; inputs driven 1 time unit after each rising edge.
module tb_fixed_act_cast_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din [1];
    logic        din_vld;
    logic        rdy;
    logic [7:0]  dout [1];
    logic        dout_vld;
    logic        dout_rdy;
    logic [15:0] satc;

    logic [15:0] din4 [1];
    logic        din4_vld;
    logic        rdy4;
    logic [7:0]  dout4 [1];
    logic        dout4_vld;
    logic        dout4_rdy;
    logic [3:0]  satc4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fixed_act_cast_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din),
        .data_in_0_valid  (din_vld),
        .data_in_0_ready  (rdy),
        .data_out_0       (dout),
        .data_out_0_valid (dout_vld),
        .data_out_0_ready (dout_rdy),
        .sat_count        (satc)
    );

    fixed_act_cast_pipe #(.SAT_CNT_WIDTH(4)) dut4 (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din4),
        .data_in_0_valid  (din4_vld),
        .data_in_0_ready  (rdy4),
        .data_out_0       (dout4),
        .data_out_0_valid (dout4_vld),
        .data_out_0_ready (dout4_rdy),
        .sat_count        (satc4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        din_vld   = 1'b0;
        din4_vld  = 1'b0;
        dout_rdy  = 1'b1;
        dout4_rdy = 1'b1;
        step();
        step();
        rst = 1'b1;
    endtask

    // One isolated beat: not visible after 1 cycle, visible with exp after exactly 2
    task automatic send_one(input logic [15:0] x, input logic [7:0] exp, input string nm);
        din[0]  = x;
        din_vld = 1'b1;
        #1;
        n_cmp++;
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL %s_rdy: got %b want 1", nm, rdy); end
        step();
        din_vld = 1'b0;
        n_cmp++;
        if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL %s_early: valid %b want 0 after 1 cycle", nm, dout_vld); end
        step();
        n_cmp++;
        if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL %s_lat: valid %b want 1 after 2 cycles", nm, dout_vld); end
        n_cmp++;
        if (dout[0] !== exp) begin n_bad++; $display("FAIL %s_dat: got %h want %h", nm, dout[0], exp); end
        step();
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        din[0]   = 16'h7FFF;
        din_vld  = 1'b1;
        din4[0]  = 16'h0000;
        din4_vld = 1'b0;
        dout_rdy = 1'b1;
        dout4_rdy = 1'b1;
        step();
        step();
        n_cmp++;
        if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
        n_cmp++;
        if (dout[0] !== 8'h00) begin n_bad++; $display("FAIL reset_dat: got %h want 00", dout[0]); end
        n_cmp++;
        if (satc !== 16'h0000) begin n_bad++; $display("FAIL reset_satc: got %h want 0000", satc); end
        n_cmp++;
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        n_cmp++;
        if (satc4 !== 4'h0) begin n_bad++; $display("FAIL reset_satc4: got %h want 0", satc4); end
        rst     = 1'b1;
        din_vld = 1'b0;
        step();
        step();
        n_cmp++;
        if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_ignored_vld: got %b want 0", dout_vld); end
    endtask

    task automatic test_round();
        do_reset();
        send_one(16'h0180, 8'h18, "rnd_1p5");
        send_one(16'h0108, 8'h11, "rnd_half_up");
        send_one(16'hFFF8, 8'h00, "rnd_neg_half");
        n_cmp++;
        if (satc !== 16'd0) begin n_bad++; $display("FAIL rnd_satc: got %0d want 0", satc); end
    endtask

    task automatic test_saturation();
        do_reset();
        send_one(16'h7FFF, 8'h7F, "sat_pos");
        send_one(16'h8000, 8'h80, "sat_neg");
        n_cmp++;
        if (satc !== 16'd2) begin n_bad++; $display("FAIL sat_cnt2: got %0d want 2", satc); end
        send_one(16'h07F7, 8'h7F, "sat_edge_in");
        n_cmp++;
        if (satc !== 16'd2) begin n_bad++; $display("FAIL sat_edge_nocount: got %0d want 2", satc); end
        send_one(16'h07F8, 8'h7F, "sat_edge_out");
        n_cmp++;
        if (satc !== 16'd3) begin n_bad++; $display("FAIL sat_edge_count: got %0d want 3", satc); end
    endtask

    // Beat i carries i*16, which rounds to exactly i
    task automatic test_stream();
        int rdy_drop;
        logic exp_v;
        do_reset();
        rdy_drop = 0;
        for (int t = 0; t < 23; t++) begin
            exp_v = (t >= 2) && (t < 22);
            n_cmp++;
            if (dout_vld !== exp_v) begin n_bad++; $display("FAIL stream_vld[%0d]: got %b want %b", t, dout_vld, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if (dout[0] !== 8'(t - 2)) begin n_bad++; $display("FAIL stream_dat[%0d]: got %h want %h", t, dout[0], 8'(t - 2)); end
            end
            din[0]  = 16'(t * 16);
            din_vld = (t < 20);
            #1;
            if (t < 20 && rdy !== 1'b1) rdy_drop++;
            step();
        end
        n_cmp++;
        if (rdy_drop !== 0) begin n_bad++; $display("FAIL stream_rdy: dropped %0d times want 0", rdy_drop); end
    endtask

    task automatic test_backpressure();
        int   sent;
        int   rcvd;
        int   cyc;
        logic rdy_low_seen;
        logic was_stalled;
        logic [7:0] held;
        do_reset();
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        rdy_low_seen = 1'b0;
        was_stalled  = 1'b0;
        held = 8'h00;
        while (cyc < 40 && rcvd < 12) begin
            dout_rdy = !(cyc >= 5 && cyc <= 7);
            din_vld  = (sent < 12);
            din[0]   = 16'(sent * 16);
            #1;
            if (was_stalled) begin
                n_cmp++;
                if (dout_vld !== 1'b1 || dout[0] !== held) begin
                    n_bad++;
                    $display("FAIL bp_hold[%0d]: got vld %b dat %h want vld 1 dat %h", cyc, dout_vld, dout[0], held);
                end
            end
            if (!dout_rdy && !rdy) rdy_low_seen = 1'b1;
            if (dout_vld && dout_rdy) begin
                n_cmp++;
                if (dout[0] !== 8'(rcvd)) begin n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", rcvd, dout[0], 8'(rcvd)); end
                rcvd++;
            end
            was_stalled = dout_vld && !dout_rdy;
            held        = dout[0];
            if (din_vld && rdy) sent++;
            step();
            cyc++;
        end
        n_cmp++;
        if (rcvd !== 12) begin n_bad++; $display("FAIL bp_count: received %0d want 12", rcvd); end
        n_cmp++;
        if (rdy_low_seen !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_drop: seen %b want 1", rdy_low_seen); end
        din_vld  = 1'b0;
        dout_rdy = 1'b1;
        step();
        step();
        n_cmp++;
        if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: valid %b want 0", dout_vld); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        din[0]  = 16'h7FFF;
        din_vld = 1'b1;
        step();
        din[0]  = 16'h0180;
        step();
        n_cmp++;
        if (dout_vld !== 1'b1 || satc !== 16'd1) begin
            n_bad++;
            $display("FAIL mid_pre: got vld %b satc %0d want vld 1 satc 1", dout_vld, satc);
        end
        rst     = 1'b0;
        din[0]  = 16'h0108;
        step();
        n_cmp++;
        if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL mid_vld: got %b want 0", dout_vld); end
        n_cmp++;
        if (satc !== 16'd0) begin n_bad++; $display("FAIL mid_satc: got %0d want 0", satc); end
        n_cmp++;
        if (dout[0] !== 8'h00) begin n_bad++; $display("FAIL mid_dat: got %h want 00", dout[0]); end
        rst     = 1'b1;
        din[0]  = 16'h07F7;
        din_vld = 1'b1;
        step();
        din_vld = 1'b0;
        n_cmp++;
        if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL mid_discard: got %b want 0", dout_vld); end
        step();
        n_cmp++;
        if (dout_vld !== 1'b1 || dout[0] !== 8'h7F) begin
            n_bad++;
            $display("FAIL mid_post: got vld %b dat %h want vld 1 dat 7f", dout_vld, dout[0]);
        end
        step();
        n_cmp++;
        if (dout_vld !== 1'b0 || satc !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_tail: got vld %b satc %0d want vld 0 satc 0", dout_vld, satc);
        end
    endtask

    // Beat k reaches stage B at the end of cycle k+1, so at the start of cycle i the count is i-1
    task automatic test_cnt_sat();
        do_reset();
        n_cmp++;
        if (satc4 !== 4'h0) begin n_bad++; $display("FAIL cnt4_init: got %h want 0", satc4); end
        for (int i = 0; i < 20; i++) begin
            if (i == 15) begin
                n_cmp++;
                if (satc4 !== 4'hE) begin n_bad++; $display("FAIL cnt4_pre: got %h want e", satc4); end
            end
            din4[0]  = 16'h7FFF;
            din4_vld = 1'b1;
            #1;
            n_cmp++;
            if (rdy4 !== 1'b1) begin n_bad++; $display("FAIL cnt4_rdy[%0d]: got %b want 1", i, rdy4); end
            step();
        end
        din4_vld = 1'b0;
        step();
        n_cmp++;
        if (dout4_vld !== 1'b1 || dout4[0] !== 8'h7F) begin
            n_bad++;
            $display("FAIL cnt4_last: got vld %b dat %h want vld 1 dat 7f", dout4_vld, dout4[0]);
        end
        step();
        step();
        n_cmp++;
        if (satc4 !== 4'hF) begin n_bad++; $display("FAIL cnt4_stick: got %h want f", satc4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        din[0]    = 16'h0000;
        din_vld   = 1'b0;
        dout_rdy  = 1'b1;
        din4[0]   = 16'h0000;
        din4_vld  = 1'b0;
        dout4_rdy = 1'b1;
        test_reset();
        test_round();
        test_saturation();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_cnt_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
